// File: rtl/song_sequencer_if.sv
// Purpose : bundles the song sequencer's control, song ROM and note/status
//           signals into one interface.
// Modports: master - controller side (beat tick, commands, loop level, ROM data)
//           slave  - song_sequencer side (ROM address, note code, status flags)
interface song_sequencer_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              beat_tick;
   logic              start;
   logic              pause;
   logic              stop;
   logic              loop_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic [3:0]        note;
   logic              playing;
   logic              paused;
   logic              done;

   modport master (
      output beat_tick, start, pause, stop, loop_en, rom_data,
      input  rom_addr, note, playing, paused, done
   );

   modport slave (
      input  beat_tick, start, pause, stop, loop_en, rom_data,
      output rom_addr, note, playing, paused, done
   );
endinterface

// File: rtl/song_sequencer.sv
// Purpose : autoplay controller. Steps through a synchronous song ROM, holds
//           each note for dur beat ticks, inserts a silent gap after each note,
//           and supports start, pause/resume, stop and looping.
// Ports   : CLK   - system clock
//           RESET - asynchronous, active-high reset
//           bus   - song_sequencer_if.slave: beat_tick/start/pause/stop/loop_en
//                   and rom_data in; rom_addr, note, playing, paused, done out
//                   (all outputs registered)
module song_sequencer #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned SONG_LEN  = 62,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   song_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_PAUSED, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
   localparam logic [3:0]        GAP_CNT   = 4'(GAP_TICKS);

   state_t     state;
   state_t     saved_state;
   logic [3:0] cnt;
   logic [3:0] note_lat;
   logic       pause_pend;

   logic [3:0] rom_dur;
   logic [3:0] rom_note;
   logic       adv_c;
   logic       eos_c;

   assign rom_dur  = bus.rom_data[7:4];
   assign rom_note = bus.rom_data[3:0];

   // Step decode: adv_c = finished the current entry, eos_c = song end reached
   always_comb begin
      adv_c = 1'b0;
      eos_c = 1'b0;
      if (!bus.stop) begin
         if (bus.beat_tick && !bus.pause && cnt == 4'd1) begin
            if (state == S_GAP)
               adv_c = 1'b1;
            if (state == S_PLAY && !pause_pend && GAP_TICKS == 0)
               adv_c = 1'b1;
         end
         eos_c = (adv_c && bus.rom_addr == LAST_ADDR) ||
                 (state == S_WAIT && rom_dur == 4'd0);
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= S_IDLE;
         saved_state  <= S_IDLE;
         cnt          <= 4'd0;
         note_lat     <= 4'd0;
         pause_pend   <= 1'b0;
         bus.rom_addr <= '0;
         bus.note     <= 4'd0;
         bus.playing  <= 1'b0;
         bus.paused   <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.stop) begin
            state        <= S_IDLE;
            saved_state  <= S_IDLE;
            cnt          <= 4'd0;
            pause_pend   <= 1'b0;
            bus.rom_addr <= '0;
            bus.note     <= 4'd0;
            bus.playing  <= 1'b0;
            bus.paused   <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     state        <= S_FETCH;
                     bus.rom_addr <= '0;
                     bus.playing  <= 1'b1;
                     pause_pend   <= 1'b0;
                  end
               end
               S_FETCH: begin
                  // pause here is remembered and honoured on the first PLAY cycle
                  if (bus.pause) pause_pend <= 1'b1;
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus.pause) pause_pend <= 1'b1;
                  if (rom_dur != 4'd0) begin
                     note_lat <= rom_note;
                     bus.note <= rom_note;
                     cnt      <= rom_dur;
                     state    <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (bus.pause || pause_pend) begin
                     state       <= S_PAUSED;
                     saved_state <= S_PLAY;
                     pause_pend  <= 1'b0;
                     bus.note    <= 4'd0;
                     bus.playing <= 1'b0;
                     bus.paused  <= 1'b1;
                  end else if (bus.beat_tick) begin
                     if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                     end else if (GAP_TICKS > 0) begin
                        state    <= S_GAP;
                        cnt      <= GAP_CNT;
                        bus.note <= 4'd0;
                     end
                  end
               end
               S_GAP: begin
                  if (bus.pause) begin
                     state       <= S_PAUSED;
                     saved_state <= S_GAP;
                     bus.playing <= 1'b0;
                     bus.paused  <= 1'b1;
                  end else if (bus.beat_tick && cnt > 4'd1) begin
                     cnt <= cnt - 4'd1;
                  end
               end
               S_PAUSED: begin
                  // cnt and rom_addr are simply held while paused
                  if (bus.pause) begin
                     state       <= saved_state;
                     bus.paused  <= 1'b0;
                     bus.playing <= 1'b1;
                     bus.note    <= (saved_state == S_PLAY) ? note_lat : 4'd0;
                  end
               end
               default: state <= S_IDLE;
            endcase

            // Entry advance and end-of-song take precedence over the case above
            if (eos_c) begin
               bus.note <= 4'd0;
               if (bus.loop_en) begin
                  state        <= S_FETCH;
                  bus.rom_addr <= '0;
                  bus.playing  <= 1'b1;
               end else begin
                  state       <= S_DONE;
                  bus.done    <= 1'b1;
                  bus.playing <= 1'b0;
                  pause_pend  <= 1'b0;
               end
            end else if (adv_c) begin
               state        <= S_FETCH;
               bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
               bus.note     <= 4'd0;
            end
         end
      end
   end
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus randomized songs checked
// against a tick-interval model of the expected note/address sequence.
`timescale 1ns/1ps
module tb_song_sequencer;
   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned SONG_LEN  = 3;
   localparam int unsigned GAP_TICKS = 1;

   logic CLK = 1'b0;
   logic RESET;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_seen = 0;
   logic [7:0] rom [0:63];
   int   exp_note [$];
   int   exp_addr [$];

   song_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   song_sequencer #(
      .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus.slave)
   );

   always #5 CLK = ~CLK;

   // synchronous song ROM
   always @(posedge CLK) bus.rom_data <= rom[bus.rom_addr];

   always @(posedge CLK) if (bus.done === 1'b1) done_seen <= done_seen + 1;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_n(input int n);
      repeat (n) cyc();
   endtask

   task automatic tick();
      bus.beat_tick = 1'b1;
      cyc();
      bus.beat_tick = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic do_pause();
      bus.pause = 1'b1;
      cyc();
      bus.pause = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      cyc();
   endtask

   // Expands the song into one expected (note, addr) pair per beat interval.
   task automatic build_model(input bit loop, input int max_iv, output int fin_addr);
      int a;
      int d;
      int nt;
      exp_note.delete();
      exp_addr.delete();
      a = 0;
      fin_addr = 0;
      for (int guard = 0; guard < 1000 && exp_note.size() < max_iv; guard++) begin
         d  = int'(rom[a][7:4]);
         nt = int'(rom[a][3:0]);
         if (d == 0) begin
            if (!loop) begin fin_addr = a; break; end
            a = 0;
            continue;
         end
         repeat (d) begin exp_note.push_back(nt); exp_addr.push_back(a); end
         repeat (GAP_TICKS) begin exp_note.push_back(0); exp_addr.push_back(a); end
         if (a == SONG_LEN - 1) begin
            if (!loop) begin fin_addr = a; break; end
            a = 0;
         end else begin
            a++;
         end
      end
   endtask

   task automatic run_song(input string name, input bit loop, input int max_iv);
      int fin;
      int d0;
      int n;
      build_model(loop, loop ? max_iv : 1000, fin);
      n = exp_note.size();
      bus.loop_en = loop;
      d0 = done_seen;
      do_start();
      wait_n($urandom_range(6, 12));
      for (int k = 0; k < n; k++) begin
         n_tests++;
         if (bus.note !== 4'(exp_note[k]) || bus.rom_addr !== ADDR_W'(exp_addr[k]) || bus.playing !== 1'b1) begin
            n_fail++;
            $display("FAIL %s iv%0d: note=%0d addr=%0d playing=%b, required note=%0d addr=%0d playing=1",
                     name, k, bus.note, bus.rom_addr, bus.playing, exp_note[k], exp_addr[k]);
         end
         tick();
         wait_n($urandom_range(6, 12));
      end
      n_tests++;
      if (!loop) begin
         if (bus.note !== 4'd0 || bus.playing !== 1'b0 || bus.rom_addr !== ADDR_W'(fin) || done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL %s end: note=%0d playing=%b addr=%0d dones=%0d, required 0 0 %0d 1",
                     name, bus.note, bus.playing, bus.rom_addr, done_seen - d0, fin);
         end
      end else begin
         if (bus.playing !== 1'b1 || done_seen - d0 != 0) begin
            n_fail++;
            $display("FAIL %s loop: playing=%b dones=%0d, required 1 0", name, bus.playing, done_seen - d0);
         end
      end
      do_stop();
   endtask

   task automatic test_reset();
      n_tests++;
      if (bus.note !== 4'd0 || bus.rom_addr !== '0 || bus.playing !== 1'b0 || bus.paused !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: note=%0d addr=%0d playing=%b paused=%b done=%b, required all 0",
                  bus.note, bus.rom_addr, bus.playing, bus.paused, bus.done);
      end
   endtask

   task automatic test_basic_song();
      rom[0] = 8'h23; rom[1] = 8'h15; rom[2] = 8'h00;
      run_song("basic", 1'b0, 0);
   endtask

   task automatic test_loop();
      rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h13;
      run_song("loop_on", 1'b1, 10);
      run_song("loop_off", 1'b0, 0);
   endtask

   task automatic test_pause();
      rom[0] = 8'h82; rom[1] = 8'h00;
      bus.loop_en = 1'b0;
      do_start();
      wait_n(6);
      repeat (5) begin tick(); wait_n(3); end
      do_pause();
      n_tests++;
      if (bus.note !== 4'd0 || bus.paused !== 1'b1 || bus.playing !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_enter: note=%0d paused=%b playing=%b, required 0 1 0", bus.note, bus.paused, bus.playing);
      end
      repeat (4) begin tick(); wait_n(3); end
      n_tests++;
      if (bus.note !== 4'd0 || bus.paused !== 1'b1 || bus.rom_addr !== '0) begin
         n_fail++;
         $display("FAIL pause_hold: note=%0d paused=%b addr=%0d, required 0 1 0", bus.note, bus.paused, bus.rom_addr);
      end
      do_pause();
      n_tests++;
      if (bus.note !== 4'd2 || bus.paused !== 1'b0 || bus.playing !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_resume: note=%0d paused=%b playing=%b, required 2 0 1", bus.note, bus.paused, bus.playing);
      end
      tick(); wait_n(3); tick(); wait_n(3);
      n_tests++;
      if (bus.note !== 4'd2) begin
         n_fail++;
         $display("FAIL pause_remaining: note=%0d after 2 ticks, required 2", bus.note);
      end
      tick(); wait_n(3);
      n_tests++;
      if (bus.note !== 4'd0) begin
         n_fail++;
         $display("FAIL pause_gap: note=%0d after 3 ticks, required 0", bus.note);
      end
      do_stop();
      // pause issued during FETCH is deferred to the first PLAY cycle
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
      wait_n(4);
      n_tests++;
      if (bus.paused !== 1'b1 || bus.note !== 4'd0) begin
         n_fail++;
         $display("FAIL pause_deferred: paused=%b note=%0d, required 1 0", bus.paused, bus.note);
      end
      do_pause();
      n_tests++;
      if (bus.note !== 4'd2 || bus.paused !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_deferred_resume: note=%0d paused=%b, required 2 0", bus.note, bus.paused);
      end
      do_stop();
   endtask

   task automatic test_stop_pause();
      rom[0] = 8'h14; rom[1] = 8'h00;
      bus.loop_en = 1'b0;
      do_start();
      wait_n(6);
      tick();
      wait_n(2);
      bus.stop = 1'b1; bus.pause = 1'b1;
      cyc();
      bus.stop = 1'b0; bus.pause = 1'b0;
      n_tests++;
      if (bus.note !== 4'd0 || bus.paused !== 1'b0 || bus.rom_addr !== '0 || bus.playing !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_pause: note=%0d paused=%b addr=%0d playing=%b, required all 0",
                  bus.note, bus.paused, bus.rom_addr, bus.playing);
      end
      do_pause();
      wait_n(2);
      n_tests++;
      if (bus.paused !== 1'b0 || bus.playing !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_pause: paused=%b playing=%b, required 0 0", bus.paused, bus.playing);
      end
      do_start();
      wait_n(6);
      n_tests++;
      if (bus.note !== 4'd4 || bus.paused !== 1'b0 || bus.playing !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_after_stop: note=%0d paused=%b playing=%b, required 4 0 1", bus.note, bus.paused, bus.playing);
      end
      do_stop();
   endtask

   task automatic test_wait_tick();
      rom[0] = 8'h26; rom[1] = 8'h00;
      bus.loop_en = 1'b0;
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      cyc();
      tick();
      wait_n(3);
      n_tests++;
      if (bus.note !== 4'd6) begin
         n_fail++;
         $display("FAIL wait_tick_play: note=%0d, required 6", bus.note);
      end
      tick(); wait_n(3);
      n_tests++;
      if (bus.note !== 4'd6) begin
         n_fail++;
         $display("FAIL wait_tick_dropped: note=%0d after 1 tick, required 6", bus.note);
      end
      tick(); wait_n(3);
      n_tests++;
      if (bus.note !== 4'd0) begin
         n_fail++;
         $display("FAIL wait_tick_len: note=%0d after 2 ticks, required 0", bus.note);
      end
      do_stop();
   endtask

   task automatic test_async_reset();
      rom[0] = 8'h47; rom[1] = 8'h00;
      bus.loop_en = 1'b0;
      do_start();
      wait_n(6);
      tick();
      wait_n(2);
      #2 RESET = 1'b1;
      #1;
      n_tests++;
      if (bus.note !== 4'd0 || bus.rom_addr !== '0 || bus.playing !== 1'b0 || bus.paused !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: note=%0d addr=%0d playing=%b paused=%b done=%b, required all 0",
                  bus.note, bus.rom_addr, bus.playing, bus.paused, bus.done);
      end
      wait_n(2);
      RESET = 1'b0;
      wait_n(4);
      n_tests++;
      if (bus.playing !== 1'b0 || bus.note !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_no_autoplay: playing=%b note=%0d, required 0 0", bus.playing, bus.note);
      end
      do_start();
      wait_n(6);
      n_tests++;
      if (bus.note !== 4'd7 || bus.rom_addr !== '0 || bus.playing !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_replay: note=%0d addr=%0d playing=%b, required 7 0 1", bus.note, bus.rom_addr, bus.playing);
      end
      do_stop();
   endtask

   task automatic test_random();
      bit lp;
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < SONG_LEN; a++) begin
            rom[a][7:4] = 4'($urandom_range(1, 15));
            rom[a][3:0] = 4'($urandom_range(0, 8));
            if (a > 0 && $urandom_range(0, 4) == 0) rom[a][7:4] = 4'd0;
         end
         lp = 1'($urandom_range(0, 1));
         run_song($sformatf("rand%0d", it), lp, $urandom_range(5, 20));
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 8'h00;
      RESET = 1'b1;
      bus.beat_tick = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop = 1'b0;
      bus.loop_en = 1'b0;
      wait_n(2);
      test_reset();
      RESET = 1'b0;
      cyc();
      test_basic_song();
      test_loop();
      test_pause();
      test_stop_pause();
      test_wait_tick();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
